pipelined_subtractor: RTL and testbench

- Parametrised, pipelined N-bit subtractor computing a - b with valid/ready handshakes on both sides.
- The operand is split into CHUNK-bit slices. One slice is resolved per pipeline stage, and the borrow is registered between stages.
- Supports wrap or saturate, in unsigned or signed interpretation, selected per transaction.
- Reports borrow and overflow flags. Sits between operand producers and result consumers in the datapath, replacing the single-cycle combinational subtractor where timing requires it.

---
 rtl/pipelined_subtractor_if.sv | 26 ++
 rtl/pipelined_subtractor.sv | 137 +++++++++++++
 tb/tb_pipelined_subtractor.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_subtractor_if.sv
// Operand/result handshake bundle for pipelined_subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface pipelined_subtractor_if #(
  parameter int unsigned N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] difference;
  logic         borrow;
  logic         overflow;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, difference, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, difference, borrow, overflow
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// Pipelined a - b: one CHUNK-bit slice per stage with a registered borrow
// between stages; the last stage applies wrap/saturate and the flags.
module pipelined_subtractor #(
  parameter int unsigned N     = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_subtractor_if.slave bus
);
  localparam int unsigned STAGES = N / CHUNK;

  typedef enum logic [1:0] {
    MODE_WRAP_U = 2'b00,
    MODE_SAT_U  = 2'b01,
    MODE_SAT_S  = 2'b10,
    MODE_WRAP_S = 2'b11
  } mode_e;

  logic [STAGES-1:0]          r_v;
  logic [STAGES-1:0][N-1:0]   r_a;
  logic [STAGES-1:0][N-1:0]   r_b;
  logic [STAGES-1:0][N-1:0]   r_res;
  logic [STAGES-1:0][1:0]     r_mode;
  logic [STAGES-1:0]          r_bor;
  logic                       r_ovf;

  logic [STAGES-1:0]          w_en;
  logic [STAGES-1:0]          w_sv;
  logic [STAGES-1:0]          w_sbin;
  logic [STAGES-1:0]          w_nbor;
  logic [STAGES-1:0][N-1:0]   w_sa;
  logic [STAGES-1:0][N-1:0]   w_sb;
  logic [STAGES-1:0][N-1:0]   w_sres;
  logic [STAGES-1:0][N-1:0]   w_nres;
  logic [STAGES-1:0][1:0]     w_smode;
  logic [STAGES-1:0][CHUNK:0] w_sl;
  logic [N-1:0]               w_raw;
  logic [N-1:0]               w_fin;
  logic                       w_fin_ovf;
  logic                       w_sovf;
  logic                       w_amsb;
  logic                       w_unused;

  // Ready chain walked from the output back: a stage may load when it is
  // empty or everything downstream of it is moving.
  always_comb begin : ready_chain
    logic l_acc;
    l_acc = bus.out_ready;
    w_en  = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      l_acc = !r_v[STAGES-1-i] || l_acc;
      w_en[STAGES-1-i] = l_acc;
    end
  end

  always_comb begin : stage_src
    w_sv    = '0;
    w_sa    = '0;
    w_sb    = '0;
    w_smode = '0;
    w_sres  = '0;
    w_sbin  = '0;
    w_sv[0]    = bus.in_valid;
    w_sa[0]    = bus.a;
    w_sb[0]    = bus.b;
    w_smode[0] = bus.mode;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_sv[k]    = r_v[k-1];
      w_sa[k]    = r_a[k-1];
      w_sb[k]    = r_b[k-1];
      w_smode[k] = r_mode[k-1];
      w_sres[k]  = r_res[k-1];
      w_sbin[k]  = r_bor[k-1];
    end
  end

  always_comb begin : slice_sub
    w_sl   = '0;
    w_nres = w_sres;
    w_nbor = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_sl[k] = {1'b0, w_sa[k][k*CHUNK +: CHUNK]}
              - {1'b0, w_sb[k][k*CHUNK +: CHUNK]}
              - {{CHUNK{1'b0}}, w_sbin[k]};
      w_nres[k][k*CHUNK +: CHUNK] = w_sl[k][CHUNK-1:0];
      w_nbor[k] = w_sl[k][CHUNK];
    end
  end

  always_comb begin : final_stage
    w_raw     = w_nres[STAGES-1];
    w_amsb    = w_sa[STAGES-1][N-1];
    w_sovf    = (w_amsb != w_sb[STAGES-1][N-1]) && (w_raw[N-1] != w_amsb);
    w_fin_ovf = w_smode[STAGES-1][1] ? w_sovf : w_nbor[STAGES-1];
    w_fin     = w_raw;
    case (mode_e'(w_smode[STAGES-1]))
      MODE_SAT_U: if (w_nbor[STAGES-1]) w_fin = '0;
      MODE_SAT_S: if (w_sovf) w_fin = w_amsb ? {1'b1, {(N-1){1'b0}}}
                                             : {1'b0, {(N-1){1'b1}}};
      default:    w_fin = w_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_mode <= '0;
      r_bor  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_v[k]    <= w_sv[k];
          r_a[k]    <= w_sa[k];
          r_b[k]    <= w_sb[k];
          r_mode[k] <= w_smode[k];
          r_bor[k]  <= w_nbor[k];
          r_res[k]  <= (k == STAGES-1) ? w_fin : w_nres[k];
        end
      end
      if (w_en[STAGES-1]) r_ovf <= w_fin_ovf;
    end
  end

  // Operand slices already consumed and the last stage's copy are dead.
  assign w_unused = ^{r_a, r_b, r_mode, w_sa, w_sb};

  assign bus.in_ready   = rst_n && w_en[0];
  assign bus.out_valid  = r_v[STAGES-1];
  assign bus.difference = r_res[STAGES-1];
  assign bus.borrow     = r_bor[STAGES-1];
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: N=8/CHUNK=4 and N=16/CHUNK=4 instances
// checked against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_pipelined_subtractor;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  pipelined_subtractor_if #(.N(8))  if8 ();
  pipelined_subtractor_if #(.N(16)) if16 ();

  pipelined_subtractor #(.N(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8)
  );
  pipelined_subtractor #(.N(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic bor; logic ovf; } exp_t;
  typedef struct packed {
    logic [7:0] a; logic [7:0] b; logic [1:0] mode;
    logic [7:0] d; logic bor; logic ovf;
  } v8_t;
  typedef struct packed {
    logic [15:0] a; logic [15:0] b; logic [1:0] mode;
    logic [15:0] d; logic bor; logic ovf;
  } v16_t;

  // Reference: interpret operands as integers, subtract, then apply the mode.
  function automatic exp_t ref_sub(input int unsigned w, input longint ua,
                                   input longint ub, input logic [1:0] md);
    exp_t r;
    longint lim, half, sa, sb, sd, raw;
    logic sovf;
    lim  = longint'(1) << w;
    half = lim / 2;
    sa   = (ua >= half) ? ua - lim : ua;
    sb   = (ub >= half) ? ub - lim : ub;
    sd   = sa - sb;
    raw  = (ua - ub + lim) % lim;
    sovf = (sd > half - 1) || (sd < -half);
    r.bor = (ua < ub);
    r.ovf = md[1] ? sovf : r.bor;
    case (md)
      2'b01:   r.d = r.bor ? 32'd0 : 32'(raw);
      2'b10:   r.d = (sd > half - 1) ? 32'(half - 1) : (sd < -half) ? 32'(half) : 32'(raw);
      default: r.d = 32'(raw);
    endcase
    return r;
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    if8.in_valid = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.mode = 2'b00; if8.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.mode = 2'b00; if16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b want 0", if8.in_ready);
    end
    checks++;
    if ({if8.out_valid, if8.difference, if8.borrow, if8.overflow} !== 11'h0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h b=%b o=%b want all 0",
                         if8.out_valid, if8.difference, if8.borrow, if8.overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    if8.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 1'b1 || if16.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b/%b want 1/1", if8.in_ready, if16.in_ready);
    end
    checks++;
    if (if8.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b want 0", if8.out_valid);
    end
  endtask

  task automatic test_directed();
    v8_t v[$];
    v.push_back('{8'h35, 8'h12, 2'b00, 8'h23, 1'b0, 1'b0});
    v.push_back('{8'h30, 8'h01, 2'b00, 8'h2F, 1'b0, 1'b0});
    v.push_back('{8'h10, 8'h20, 2'b00, 8'hF0, 1'b1, 1'b1});
    v.push_back('{8'h10, 8'h20, 2'b01, 8'h00, 1'b1, 1'b1});
    v.push_back('{8'h80, 8'h01, 2'b10, 8'h80, 1'b0, 1'b1});
    v.push_back('{8'h7F, 8'hFF, 2'b10, 8'h7F, 1'b1, 1'b1});
    v.push_back('{8'h7F, 8'hFF, 2'b11, 8'h80, 1'b1, 1'b1});
    v.push_back('{8'h05, 8'h07, 2'b10, 8'hFE, 1'b1, 1'b0});
    v.push_back('{8'h5A, 8'h5A, 2'b10, 8'h00, 1'b0, 1'b0});
    v.push_back('{8'h00, 8'h01, 2'b00, 8'hFF, 1'b1, 1'b1});
    v.push_back('{8'h00, 8'h01, 2'b11, 8'hFF, 1'b1, 1'b0});
    v.push_back('{8'h80, 8'h7F, 2'b11, 8'h01, 1'b0, 1'b1});
    v.push_back('{8'h00, 8'h80, 2'b10, 8'h7F, 1'b1, 1'b1});
    v.push_back('{8'hFF, 8'hFF, 2'b01, 8'h00, 1'b0, 1'b0});
    if8.out_ready = 1'b1;
    foreach (v[i]) begin
      @(posedge clk); #1;
      if8.in_valid = 1'b1; if8.a = v[i].a; if8.b = v[i].b; if8.mode = v[i].mode;
      @(negedge clk);
      checks++;
      if (if8.in_ready !== 1'b1) begin
        errors++; $display("FAIL dir_ready[%0d]: got %b want 1", i, if8.in_ready);
      end
      @(posedge clk); #1;
      if8.in_valid = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.mode = ~v[i].mode;
      @(negedge clk);
      checks++;
      if (if8.out_valid !== 1'b0) begin
        errors++; $display("FAIL dir_early[%0d]: got out_valid=%b want 0", i, if8.out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if8.out_valid, if8.difference, if8.borrow, if8.overflow} !==
          {1'b1, v[i].d, v[i].bor, v[i].ovf}) begin
        errors++; $display("FAIL dir_result[%0d]: got v=%b d=%h b=%b o=%b want v=1 d=%h b=%b o=%b",
                           i, if8.out_valid, if8.difference, if8.borrow, if8.overflow,
                           v[i].d, v[i].bor, v[i].ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got  = 0;
    if8.out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 8; c++) begin
      @(posedge clk); #1;
      if (sent < 8) begin
        if8.in_valid = 1'b1; if8.a = pick8(); if8.b = pick8(); if8.mode = 2'($urandom);
      end else begin
        if8.in_valid = 1'b0;
      end
      @(negedge clk);
      if (if8.in_valid) begin
        checks++;
        if (if8.in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready: cycle %0d got %b want 1", c, if8.in_ready);
        end
      end
      if (if8.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_phantom: cycle %0d got out_valid=1 want no result", c);
        end else begin
          e = q.pop_front();
          if ({if8.difference, if8.borrow, if8.overflow} !== {e.d[7:0], e.bor, e.ovf} || c != got + 2) begin
            errors++; $display("FAIL b2b_result[%0d]: got d=%h b=%b o=%b at cycle %0d want d=%h b=%b o=%b at cycle %0d",
                               got, if8.difference, if8.borrow, if8.overflow, c, e.d[7:0], e.bor, e.ovf, got + 2);
          end
          got++;
        end
      end
      if (if8.in_valid && if8.in_ready) begin
        q.push_back(ref_sub(8, longint'(if8.a), longint'(if8.b), if8.mode));
        sent++;
      end
    end
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL b2b_count: got %0d results want 8", got);
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    logic exp_rdy;
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(posedge clk); #1;
      if8.out_ready = (c >= 4);
      if (sent < 5) begin
        if8.in_valid = 1'b1; if8.a = pick8(); if8.b = pick8(); if8.mode = 2'($urandom);
      end else begin
        if8.in_valid = 1'b0;
      end
      @(negedge clk);
      exp_rdy = (q.size() < 2) || if8.out_ready;
      checks++;
      if (if8.in_ready !== exp_rdy) begin
        errors++; $display("FAIL bp_ready: cycle %0d got %b want %b", c, if8.in_ready, exp_rdy);
      end
      if (c == 2) begin
        checks++;
        if (if8.in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_full: got in_ready=%b want 0 with two held", if8.in_ready);
        end
      end
      if (if8.out_valid && if8.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_phantom: cycle %0d got extra result want none", c);
        end else begin
          e = q.pop_front();
          if ({if8.difference, if8.borrow, if8.overflow} !== {e.d[7:0], e.bor, e.ovf}) begin
            errors++; $display("FAIL bp_result[%0d]: got d=%h b=%b o=%b want d=%h b=%b o=%b",
                               got, if8.difference, if8.borrow, if8.overflow, e.d[7:0], e.bor, e.ovf);
          end
          got++;
        end
      end
      if (if8.in_valid && if8.in_ready) begin
        q.push_back(ref_sub(8, longint'(if8.a), longint'(if8.b), if8.mode));
        sent++;
      end
    end
    checks++;
    if (got != 5 || sent != 5) begin
      errors++; $display("FAIL bp_count: got sent=%0d recv=%0d want 5/5", sent, got);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b1; if8.a = 8'h44; if8.b = 8'h11; if8.mode = 2'b00;
    @(posedge clk); #1;
    if8.a = 8'h20; if8.b = 8'h30;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_inflight: got out_valid=%b in_ready=%b want 1/0", if8.out_valid, if8.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    if8.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({if8.out_valid, if8.difference, if8.borrow, if8.overflow, if8.in_ready} !== 12'h001) begin
      errors++; $display("FAIL mid_cleared: got v=%b d=%h b=%b o=%b rdy=%b want 0/00/0/0/1",
                         if8.out_valid, if8.difference, if8.borrow, if8.overflow, if8.in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if8.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mid_ghost: got %0d results after reset want 0", seen);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic exp_rdy;
    logic prev_hold = 1'b0;
    logic [9:0] prev_out = '0;
    for (int c = 0; c < 440; c++) begin
      @(posedge clk); #1;
      if (c < 400) begin
        if8.in_valid  = ($urandom_range(0, 9) < 7);
        if8.a = pick8(); if8.b = pick8(); if8.mode = 2'($urandom);
        if8.out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        if8.in_valid = 1'b0; if8.out_ready = 1'b1;
      end
      @(negedge clk);
      exp_rdy = (q.size() < 2) || if8.out_ready;
      checks++;
      if (if8.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, if8.in_ready, exp_rdy);
      end
      if (prev_hold) begin
        checks++;
        if ({if8.out_valid, if8.difference, if8.borrow, if8.overflow} !== {1'b1, prev_out}) begin
          errors++; $display("FAIL rnd_hold: cycle %0d got v=%b %h want v=1 %h",
                             c, if8.out_valid, {if8.difference, if8.borrow, if8.overflow}, prev_out);
        end
      end
      prev_hold = if8.out_valid && !if8.out_ready;
      prev_out  = {if8.difference, if8.borrow, if8.overflow};
      if (if8.out_valid && if8.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_phantom: cycle %0d got extra result want none", c);
        end else begin
          e = q.pop_front();
          if ({if8.difference, if8.borrow, if8.overflow} !== {e.d[7:0], e.bor, e.ovf}) begin
            errors++; $display("FAIL rnd_result: cycle %0d got d=%h b=%b o=%b want d=%h b=%b o=%b",
                               c, if8.difference, if8.borrow, if8.overflow, e.d[7:0], e.bor, e.ovf);
          end
        end
      end
      if (if8.in_valid && if8.in_ready)
        q.push_back(ref_sub(8, longint'(if8.a), longint'(if8.b), if8.mode));
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rnd_drain: got %0d results missing want 0", q.size());
    end
  endtask

  task automatic test_n16();
    v16_t v[$];
    v16_t t;
    exp_t e;
    v.push_back('{16'h1000, 16'h0001, 2'b00, 16'h0FFF, 1'b0, 1'b0});
    v.push_back('{16'h0001, 16'h0002, 2'b00, 16'hFFFF, 1'b1, 1'b1});
    for (int i = 0; i < 10; i++) begin
      t.a = 16'($urandom); t.b = 16'($urandom); t.mode = 2'($urandom);
      e = ref_sub(16, longint'(t.a), longint'(t.b), t.mode);
      t.d = e.d[15:0]; t.bor = e.bor; t.ovf = e.ovf;
      v.push_back(t);
    end
    if16.out_ready = 1'b1;
    foreach (v[i]) begin
      @(posedge clk); #1;
      if16.in_valid = 1'b1; if16.a = v[i].a; if16.b = v[i].b; if16.mode = v[i].mode;
      @(negedge clk);
      checks++;
      if (if16.in_ready !== 1'b1) begin
        errors++; $display("FAIL n16_ready[%0d]: got %b want 1", i, if16.in_ready);
      end
      @(posedge clk); #1;
      if16.in_valid = 1'b0; if16.mode = ~v[i].mode; if16.a = 16'($urandom); if16.b = 16'($urandom);
      for (int k = 1; k <= 3; k++) begin
        if (k > 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (if16.out_valid !== 1'b0) begin
          errors++; $display("FAIL n16_early[%0d]: cycle %0d after accept got out_valid=1 want 0", i, k);
        end
        if16.mode = 2'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if16.out_valid, if16.difference, if16.borrow, if16.overflow} !==
          {1'b1, v[i].d, v[i].bor, v[i].ovf}) begin
        errors++; $display("FAIL n16_result[%0d]: got v=%b d=%h b=%b o=%b want v=1 d=%h b=%b o=%b",
                           i, if16.out_valid, if16.difference, if16.borrow, if16.overflow,
                           v[i].d, v[i].bor, v[i].ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_n16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
